aes128_iter_ctrl: RTL and testbench

AES128_ITER_CTRL -- requirements
Module: aes128_iter_ctrl

---
 rtl/aes_pkg.sv | 43 ++++
 rtl/aes_round_unit.sv | 50 +++++
 rtl/aes128_iter_ctrl.sv | 96 +++++++++
 tb/tb_aes128_iter_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants and helpers: S-box, round constants, controller states, GF(2^8) doubling.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } ctrl_state_e;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Entries 11..15 pad the table so a 4-bit round counter can index it directly.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_unit
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [7:0]   sb_s [16];
  logic [7:0]   sr_s [16];
  logic [127:0] sr_flat_s;
  logic [127:0] mc_s;

  // Byte i sits at bits [127-8i -: 8]; byte index = row + 4*column.
  always_comb begin
    sr_flat_s = 128'h0;
    mc_s      = 128'h0;
    for (int i = 0; i < 16; i++) begin
      sb_s[i] = SBOX[state_in[127-8*i -: 8]];
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[r+4*c] = sb_s[r+4*((c+r)%4)];
      end
    end
    for (int i = 0; i < 16; i++) begin
      sr_flat_s[127-8*i -: 8] = sr_s[i];
    end
    for (int c = 0; c < 4; c++) begin
      mc_s[127-32*c -: 32] = {
        xtime(sr_s[4*c]) ^ xtime(sr_s[4*c+1]) ^ sr_s[4*c+1] ^ sr_s[4*c+2] ^ sr_s[4*c+3],
        sr_s[4*c] ^ xtime(sr_s[4*c+1]) ^ xtime(sr_s[4*c+2]) ^ sr_s[4*c+2] ^ sr_s[4*c+3],
        sr_s[4*c] ^ sr_s[4*c+1] ^ xtime(sr_s[4*c+2]) ^ xtime(sr_s[4*c+3]) ^ sr_s[4*c+3],
        xtime(sr_s[4*c]) ^ sr_s[4*c] ^ sr_s[4*c+1] ^ sr_s[4*c+2] ^ xtime(sr_s[4*c+3])
      };
    end
  end

  // Final round skips MixColumns.
  always_comb begin
    if (last_round) begin
      state_out = sr_flat_s ^ round_key;
    end else begin
      state_out = mc_s ^ round_key;
    end
  end

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one shared round unit reused ten times, key schedule expanded on the fly.
module aes128_iter_ctrl
  import aes_pkg::*;
(
  input  logic         eph1,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] pt_data,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [127:0] enc_data
);

  ctrl_state_e  fsm_r;
  logic [127:0] state_r;
  logic [127:0] key_r;
  logic [3:0]   round_cnt_r;
  logic         busy_r;
  logic         done_r;
  logic [127:0] enc_data_r;

  logic [127:0] next_key_s;
  logic [127:0] round_out_s;
  logic         last_round_s;

  assign busy     = busy_r;
  assign done     = done_r;
  assign enc_data = enc_data_r;

  // Next round key derived from the current one; no schedule is stored.
  always_comb begin
    logic [31:0] w0, w1, w2, w3;
    w0 = key_r[127:96] ^ sub_word({key_r[23:0], key_r[31:24]}) ^ {RCON[round_cnt_r], 24'h000000};
    w1 = key_r[95:64] ^ w0;
    w2 = key_r[63:32] ^ w1;
    w3 = key_r[31:0]  ^ w2;
    next_key_s   = {w0, w1, w2, w3};
    last_round_s = (fsm_r == FINAL);
  end

  aes_round_unit u_round (
    .state_in   (state_r),
    .round_key  (next_key_s),
    .last_round (last_round_s),
    .state_out  (round_out_s)
  );

  // Controller FSM; busy stays high through the done cycle so start is only taken afterwards.
  always_ff @(posedge eph1) begin
    if (reset) begin
      fsm_r       <= IDLE;
      state_r     <= 128'h0;
      key_r       <= 128'h0;
      round_cnt_r <= 4'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      enc_data_r  <= 128'h0;
    end else begin
      case (fsm_r)
        IDLE: begin
          done_r <= 1'b0;
          if (busy_r) begin
            busy_r <= 1'b0;
          end else if (start) begin
            state_r     <= pt_data ^ key;
            key_r       <= key;
            round_cnt_r <= 4'd1;
            busy_r      <= 1'b1;
            fsm_r       <= ROUND;
          end
        end
        ROUND: begin
          state_r     <= round_out_s;
          key_r       <= next_key_s;
          round_cnt_r <= round_cnt_r + 4'd1;
          if (round_cnt_r == 4'd9) begin
            fsm_r <= FINAL;
          end
        end
        FINAL: begin
          enc_data_r  <= round_out_s;
          done_r      <= 1'b1;
          round_cnt_r <= 4'd0;
          fsm_r       <= IDLE;
        end
        default: begin
          fsm_r  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Scoreboard bench for aes128_iter_ctrl: stimulus pushes expected ciphertext and done cycle, a monitor pops on done.
module tb_aes128_iter_ctrl;

  logic         eph1 = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] pt_data = 128'h0;
  logic [127:0] key = 128'h0;
  logic         busy;
  logic         done;
  logic [127:0] enc_data;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R2 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes128_iter_ctrl dut (
    .eph1     (eph1),
    .reset    (reset),
    .start    (start),
    .pt_data  (pt_data),
    .key      (key),
    .busy     (busy),
    .done     (done),
    .enc_data (enc_data)
  );

  always #5 eph1 = ~eph1;

  int cyc = 0;
  always @(posedge eph1) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t         sb_q [$];
  exp_t         mon_e;
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [127:0] held_exp = 128'h0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pops one expectation; otherwise enc_data must hold its last value.
  always @(negedge eph1) begin
    if (!reset) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 with enc_data %h, expected no done (cycle %0d)", enc_data, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          check("enc_data", enc_data, mon_e.data);
          check("done_cycle", 128'(cyc), 128'(mon_e.cyc));
          held_exp = mon_e.data;
        end
      end else begin
        check("enc_hold", enc_data, held_exp);
      end
    end
  end

  // Called just after a posedge with busy low; the next edge accepts the block.
  task automatic issue(input logic [127:0] p, input logic [127:0] k, input logic [127:0] e, input bit push);
    pt_data = p;
    key     = k;
    start   = 1'b1;
    @(posedge eph1); #1;
    start = 1'b0;
    if (push) sb_q.push_back('{e, cyc + 10});
    check("busy_after_accept", 128'(busy), 128'h1);
  endtask

  task automatic drain();
    int t = 0;
    while ((sb_q.size() != 0 || busy) && t < 60) begin
      @(posedge eph1); #1;
      t++;
    end
    check("drain_in_time", 128'(t < 60), 128'h1);
  endtask

  initial begin
    repeat (3) @(posedge eph1);
    #1;
    check("reset_busy", 128'(busy), 128'h0);
    check("reset_done", 128'(done), 128'h0);
    check("reset_enc", enc_data, 128'h0);
    check("reset_round_cnt", 128'(dut.round_cnt_r), 128'h0);
    reset = 1'b0;
    @(posedge eph1); #1;

    issue(P1, K1, C1, 1'b1);
    drain();

    issue(P2, K2, C2, 1'b1);
    @(posedge eph1); #1;
    check("round1_key", dut.key_r, R2);
    drain();

    // start held high: one block every 12 cycles
    pt_data = 128'h0;
    key     = 128'h0;
    start   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge eph1); #1;
      sb_q.push_back('{C0, cyc + 10});
      check("busy_held_start", 128'(busy), 128'h1);
      if (k == 2) start = 1'b0;
      else repeat (11) @(posedge eph1);
    end
    drain();

    // start and input noise while busy must not disturb the block
    issue(P1, K1, C1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      start   = 1'($urandom_range(0, 1));
      pt_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      key     = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge eph1); #1;
    end
    start = 1'b0;
    drain();
    repeat (15) @(posedge eph1);
    #1;

    // reset during round 5 aborts the block
    issue(P2, K2, C2, 1'b0);
    repeat (4) @(posedge eph1);
    #1;
    reset = 1'b1;
    @(posedge eph1); #1;
    reset    = 1'b0;
    held_exp = 128'h0;
    check("abort_busy", 128'(busy), 128'h0);
    check("abort_done", 128'(done), 128'h0);
    check("abort_enc", enc_data, 128'h0);
    repeat (20) @(posedge eph1);
    #1;
    issue(P2, K2, C2, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
